cs_final_add_acc: RTL
=====================

Name: cs_final_add_acc

Overview:
- Downstream neighbour of the 8-bit partial-product compressor.
- Takes the compressor's two carry-save vectors (r_a, r_b) and resolves them into the binary product with a 2-stage pipelined carry-propagate adder.
- Accumulates successive products into a wide accumulator, giving the dot-product result of a systolic-array PE.
- Uses valid/ready handshakes on both sides, with full-pipeline stall on backpressure.

Parameters:
- DWIDTH, 8, operand width; carry-save vectors are 2*DWIDTH bits.
- AWIDTH, 24, accumulator/result width; must be >= 2*DWIDTH.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  r_a/r_b/in_first/in_last are valid this cycle.
- in_ready  output  1  block can accept an input this cycle.
- r_a  input  2*DWIDTH  carry-save vector A from the compressor.
- r_b  input  2*DWIDTH  carry-save vector B from the compressor.
- in_first  input  1  term starts a new accumulation; accumulator is loaded, not added.
- in_last  input  1  term ends the accumulation; result is presented on the output.
- out_valid  output  1  out_acc/out_ovf hold a completed accumulation.
- out_ready  input  1  consumer accepts the output this cycle.
- out_acc  output  AWIDTH  accumulated unsigned result.
- out_ovf  output  1  sticky: the accumulation wrapped past 2^AWIDTH.

Behaviour:
- Reset (async, rst_n=0): all registers cleared immediately.
  - out_valid=0, out_acc=0, out_ovf=0.
  - Stage-1 valid=0, accumulator=0.
  - in_ready=1 from the first cycle after release.
- Arithmetic is unsigned. Product = (r_a + r_b) mod 2^(2*DWIDTH), zero-extended to AWIDTH.
- Stage 1 (accept cycle T, when in_valid && in_ready):
  - Registers lo = r_a[DWIDTH-1:0] + r_b[DWIDTH-1:0] as DWIDTH+1 bits, including the carry.
  - Registers the upper halves of r_a and r_b, plus first, last and s1_valid=1.
  - Without an accept, s1_valid=0 (bubble).
- Stage 2 (edge T+2, when s1_valid and not stalled):
  - prod = {hi_a + hi_b + lo[DWIDTH], lo[DWIDTH-1:0]}, truncated to 2*DWIDTH.
  - If first: acc <= prod and ovf <= 0.
  - Otherwise: acc <= (acc + prod) mod 2^AWIDTH, and ovf <= ovf | carry-out of that AWIDTH add.
  - If last: out_valid <= 1.
  - out_acc is the acc register and out_ovf is the ovf register.
- Latency: an accepted term with in_last=1 shows out_valid=1 in cycle T+2.
- Throughput: one term per cycle when not stalled.
- Output handshake:
  - out_valid stays 1 and out_acc/out_ovf stay stable until out_valid && out_ready.
  - On that transfer edge, out_valid <= 0 unless stage 2 sets it again in the same cycle. Back-to-back single-term groups give a continuous out_valid with a new value each cycle.
- Stall = out_valid && !out_ready, and while it holds:
  - in_ready=0.
  - Stage 1 and stage 2 registers hold their values; no input is accepted.
  - in_ready is combinational: in_ready = !stall.
- Non-last terms update acc without touching out_valid.
  - A non-last term cannot reach stage 2 while out_valid=1 and unaccepted, because of the stall.
  - So a presented result is never modified.
- A term with neither first nor last set while no group is open adds to the current acc value. Upstream guarantees the first/last framing; the block does not check it.
- in_first and in_last both 1: a single-term group, so out_acc = prod.
- rst_n asserted mid-group or mid-stall: all in-flight terms and any pending output are discarded, with no partial output afterwards.
- Bubbles (in_valid=0) between the terms of a group are allowed and do not change acc.

Test Plan:
- Reset release, then r_a=0x00FF, r_b=0x0001, first=last=1, out_ready=1 -> out_acc=0x000100 and out_valid pulses 1 cycle at T+2 (checks the carry crossing between halves).
- Feed compressor outputs for 200*250 (first=last=1) -> out_acc=50000, out_ovf=0.
- Four back-to-back terms of 255*255 (first on #1, last on #4) -> one out_valid, out_acc=260100; out_valid stays 0 during terms 1-3.
- AWIDTH=16, two terms 255*255 -> out_acc=64514, out_ovf=1. Next group 3*3 (first=last) -> out_acc=9, out_ovf=0.
- Hold out_ready=0 for 5 cycles while a result is valid, with in_valid=1 -> in_ready=0, out_acc stable, no input lost. Release -> the queued groups emerge in order with correct values.
- Assert rst_n=0 between term 2 and term 3 of a group -> outputs 0 immediately. A following fresh group 10*10 -> out_acc=100.

Source files
------------

// File: rtl/cs_final_add_acc.sv
// Carry-save final adder and accumulator for a systolic-array PE: resolves the
// compressor's r_a/r_b vectors in a 2-stage carry-propagate pipeline and sums products.

module cs_final_add_acc_chk #(
   parameter int AWIDTH = 24
) (
   input logic              clk,
   input logic              rst_n,
   input logic              in_ready,
   input logic              out_valid,
   input logic              out_ready,
   input logic [AWIDTH-1:0] out_acc,
   input logic              out_ovf
);

   // in_ready mirrors the stall condition, and a stalled result never moves.
   a_ready_is_not_stall: assert property (@(posedge clk) disable iff (!rst_n)
      in_ready == !(out_valid && !out_ready));

   a_result_held: assert property (@(posedge clk) disable iff (!rst_n)
      (out_valid && !out_ready) |=> (out_valid && $stable(out_acc) && $stable(out_ovf)));

endmodule

module cs_final_add_acc #(
   parameter int DWIDTH = 8,
   parameter int AWIDTH = 24
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [2*DWIDTH-1:0] r_a,
   input  logic [2*DWIDTH-1:0] r_b,
   input  logic                in_first,
   input  logic                in_last,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [AWIDTH-1:0]   out_acc,
   output logic                out_ovf
);

   localparam int PW = 2 * DWIDTH;

   // Upper half absorbs the low-half carry; the sum wraps at 2*DWIDTH bits.
   function automatic logic [PW-1:0] resolve_prod(
      input logic [DWIDTH:0]   lo,
      input logic [DWIDTH-1:0] hi_a,
      input logic [DWIDTH-1:0] hi_b
   );
      logic [DWIDTH-1:0] hi;
      hi = hi_a + hi_b + {{(DWIDTH-1){1'b0}}, lo[DWIDTH]};
      return {hi, lo[DWIDTH-1:0]};
   endfunction

   logic              stall_s;
   logic              accept_s;
   logic              advance_s;
   logic [DWIDTH:0]   lo_sum_s;
   logic [PW-1:0]     prod_s;
   logic [AWIDTH-1:0] prod_ext_s;
   logic [AWIDTH:0]   acc_sum_s;

   logic              s1_valid_r;
   logic [DWIDTH:0]   s1_lo_r;
   logic [DWIDTH-1:0] s1_hi_a_r;
   logic [DWIDTH-1:0] s1_hi_b_r;
   logic              s1_first_r;
   logic              s1_last_r;

   logic [AWIDTH-1:0] acc_r;
   logic              ovf_r;
   logic              out_valid_r;

   // Handshake control and the combinational halves of both adder stages.
   always_comb begin
      stall_s    = 1'b0;
      accept_s   = 1'b0;
      advance_s  = 1'b0;
      lo_sum_s   = {(DWIDTH+1){1'b0}};
      prod_s     = {PW{1'b0}};
      prod_ext_s = {AWIDTH{1'b0}};
      acc_sum_s  = {(AWIDTH+1){1'b0}};

      if (out_valid_r && !out_ready) begin
         stall_s = 1'b1;
      end else begin
         stall_s = 1'b0;
      end

      accept_s  = in_valid && !stall_s;
      advance_s = s1_valid_r && !stall_s;

      lo_sum_s = {1'b0, r_a[DWIDTH-1:0]} + {1'b0, r_b[DWIDTH-1:0]};

      prod_s                 = resolve_prod(s1_lo_r, s1_hi_a_r, s1_hi_b_r);
      prod_ext_s[PW-1:0]     = prod_s;
      acc_sum_s              = {1'b0, acc_r} + {1'b0, prod_ext_s};
   end

   // Stage 1: low-half add with carry, upper halves and framing flags captured.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_r <= 1'b0;
         s1_lo_r    <= {(DWIDTH+1){1'b0}};
         s1_hi_a_r  <= {DWIDTH{1'b0}};
         s1_hi_b_r  <= {DWIDTH{1'b0}};
         s1_first_r <= 1'b0;
         s1_last_r  <= 1'b0;
      end else if (!stall_s) begin
         s1_valid_r <= accept_s;
         if (accept_s) begin
            s1_lo_r    <= lo_sum_s;
            s1_hi_a_r  <= r_a[PW-1:DWIDTH];
            s1_hi_b_r  <= r_b[PW-1:DWIDTH];
            s1_first_r <= in_first;
            s1_last_r  <= in_last;
         end
      end
   end

   // Stage 2: finish the product, load or accumulate, and present on last.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_r       <= {AWIDTH{1'b0}};
         ovf_r       <= 1'b0;
         out_valid_r <= 1'b0;
      end else begin
         if (advance_s) begin
            if (s1_first_r) begin
               acc_r <= prod_ext_s;
               ovf_r <= 1'b0;
            end else begin
               acc_r <= acc_sum_s[AWIDTH-1:0];
               ovf_r <= ovf_r | acc_sum_s[AWIDTH];
            end
         end

         // A new last term re-arms out_valid on the very edge the old result leaves.
         if (advance_s && s1_last_r) begin
            out_valid_r <= 1'b1;
         end else if (out_valid_r && out_ready) begin
            out_valid_r <= 1'b0;
         end
      end
   end

   assign in_ready  = !stall_s;
   assign out_valid = out_valid_r;
   assign out_acc   = acc_r;
   assign out_ovf   = ovf_r;

   cs_final_add_acc_chk #(
      .AWIDTH (AWIDTH)
   ) u_chk (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_acc   (out_acc),
      .out_ovf   (out_ovf)
   );

endmodule
